// File: rtl/neurospike_pkg.sv
// ---------------------------------------------------------------------------
// neurospike_pkg
// Shared fixed-point definitions for the neuron-update datapath.
//   Q_FRAC  : number of fractional bits in the Q8.24 format
//   Q_WIDTH : total width of a Q8.24 word
//   q8_24_t : signed Q8.24 word type
// ---------------------------------------------------------------------------
package neurospike_pkg;

    localparam int Q_FRAC  = 24;
    localparam int Q_WIDTH = 32;

    typedef logic signed [Q_WIDTH-1:0] q8_24_t;

endpackage

// File: rtl/Q8_24_multiplier.sv
// ---------------------------------------------------------------------------
// Q8_24_multiplier
// Combinational signed Q8.24 multiplier. Forms the full 64-bit product and
// keeps bits [55:24], which rounds toward minus infinity and wraps on
// overflow (no saturation).
// Ports:
//   a_i    : signed Q8.24 operand a
//   b_i    : signed Q8.24 operand b
//   prod_o : signed Q8.24 product
// ---------------------------------------------------------------------------
module Q8_24_multiplier
    import neurospike_pkg::*;
(
    input  q8_24_t a_i,
    input  q8_24_t b_i,
    output q8_24_t prod_o
);

    logic signed [2*Q_WIDTH-1:0] fullProd;

    // Both operands are signed, so they are sign-extended to 64 bits before
    // the multiply; dropping the low Q_FRAC bits of a two's-complement value
    // is a floor, which gives truncation toward minus infinity for free.
    assign fullProd = a_i * b_i;
    assign prod_o   = fullProd[Q_FRAC+Q_WIDTH-1:Q_FRAC];

endmodule

// File: rtl/q8_24_mult_arbiter.sv
// ---------------------------------------------------------------------------
// q8_24_mult_arbiter
// Round-robin scheduler sharing one Q8_24_multiplier among N_REQ requesters.
// One operand pair is accepted per cycle, carried through a two-stage
// pipeline (S1 operands, S2 product) and returned tagged with the index of
// the requester that issued it.
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   req_valid : per-requester operand-pair valid
//   req_ready : per-requester accept strobe (one-hot or zero)
//   req_a     : packed signed Q8.24 operand a, slice i = [32i+31:32i]
//   req_b     : packed signed Q8.24 operand b, same packing
//   rsp_valid : response holds a product
//   rsp_ready : consumer accepts the response
//   rsp_id    : requester index of the product
//   rsp_prod  : signed Q8.24 product
// ---------------------------------------------------------------------------
module q8_24_mult_arbiter
    import neurospike_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [Q_WIDTH*N_REQ-1:0]   req_a,
    input  logic [Q_WIDTH*N_REQ-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [Q_WIDTH-1:0]         rsp_prod
);

    logic [ID_W-1:0]    ptr_q, ptr_d;

    logic               s1_valid_q;
    logic [ID_W-1:0]    s1_id_q;
    q8_24_t             s1_a_q, s1_b_q;

    logic               s2_valid_q;
    logic [ID_W-1:0]    s2_id_q;
    q8_24_t             s2_prod_q;

    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grantId;
    logic               grantFound;
    int                 searchIdx;

    logic               adv1, adv2;
    logic               accept;
    q8_24_t             selA, selB;
    q8_24_t             mulProd;

    // Round-robin search: walk the requesters starting at the pointer and
    // wrapping around, granting the first one that is presenting a pair.
    // Only req_valid and the pointer feed this, never the operand data.
    always_comb begin
        grant      = '0;
        grantId    = '0;
        grantFound = 1'b0;
        searchIdx  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            searchIdx = (int'(ptr_q) + k) % N_REQ;
            if (!grantFound && req_valid[searchIdx]) begin
                grantFound        = 1'b1;
                grantId           = ID_W'(searchIdx);
                grant[searchIdx]  = 1'b1;
            end
        end
    end

    // Pipeline advance: S2 frees up when empty or drained this cycle, and S1
    // can take a new pair when it is empty or moving into S2. Ready is held
    // low during reset because S1 may still look full in that cycle.
    assign adv2      = !s2_valid_q || rsp_ready;
    assign adv1      = !s1_valid_q || adv2;
    assign req_ready = (adv1 && !rst) ? grant : '0;
    assign accept    = |req_ready;

    // Operand mux for the granted requester, plus the pointer update that
    // moves priority to the requester just after the one served.
    always_comb begin
        selA  = req_a[int'(grantId)*Q_WIDTH +: Q_WIDTH];
        selB  = req_b[int'(grantId)*Q_WIDTH +: Q_WIDTH];
        ptr_d = ptr_q;
        if (accept) begin
            if (grantId == ID_W'(N_REQ-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grantId + ID_W'(1);
            end
        end
    end

    Q8_24_multiplier uMult (
        .a_i    (s1_a_q),
        .b_i    (s1_b_q),
        .prod_o (mulProd)
    );

    // Pipeline and pointer registers. Data registers only load when a real
    // item arrives, so an empty stage keeps its old contents and the
    // response fields stay frozen under backpressure. Reset clears both
    // stages so anything in flight is dropped without a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_prod_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (adv1) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_id_q <= grantId;
                    s1_a_q  <= selA;
                    s1_b_q  <= selB;
                end
            end
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_id_q   <= s1_id_q;
                    s2_prod_q <= mulProd;
                end
            end
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_id    = s2_id_q;
    assign rsp_prod  = s2_prod_q;

endmodule

// File: tb/tb_q8_24_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_q8_24_mult_arbiter
// Self-checking bench for q8_24_mult_arbiter (N_REQ = 4). A transaction-level
// model (round-robin pointer plus an in-flight queue with acceptance times)
// predicts req_ready and the response port every cycle; directed scenarios
// add literal expectations, followed by a randomized handshake phase.
// ---------------------------------------------------------------------------
module tb_q8_24_mult_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  reqValid = '0;
    logic [N-1:0]  reqReady;
    logic [32*N-1:0] reqA = '0;
    logic [32*N-1:0] reqB = '0;
    logic          rspValid;
    logic          rspReady = 1'b0;
    logic [1:0]    rspId;
    logic [31:0]   rspProd;

    int checks = 0;
    int errors = 0;

    q8_24_mult_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (reqValid),
        .req_ready (reqReady),
        .req_a     (reqA),
        .req_b     (reqB),
        .rsp_valid (rspValid),
        .rsp_ready (rspReady),
        .rsp_id    (rspId),
        .rsp_prod  (rspProd)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Single comparison point: bumps the counters and reports mismatches.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive the valid vector and consumer ready for the coming cycle.
    task automatic applyStimulus(input logic [N-1:0] v, input logic rr);
        reqValid = v;
        rspReady = rr;
    endtask

    task automatic setOps(input int i, input logic [31:0] a, input logic [31:0] b);
        reqA[i*32 +: 32] = a;
        reqB[i*32 +: 32] = b;
    endtask

    task automatic toNextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        toNextCycle();
        rst = 1'b0;
    endtask

    // Reference product: floor(a*b / 2^24), wrapped to 32 bits.
    function automatic logic [31:0] prodModel(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> 24;
        return p[31:0];
    endfunction

    // ---------------------------------------------------------------------
    // Transaction model. Items in flight sit in a queue in acceptance order.
    // The front item is visible on the response port once two cycles have
    // elapsed since its acceptance. At most two items fit in flight; a new
    // one can enter when fewer than two are held or the front drains now.
    // ---------------------------------------------------------------------
    typedef struct {
        int          id;
        logic [31:0] prod;
        int          cyc;
    } item_t;

    item_t inFlight[$];
    int    mPtr  = 0;
    int    cycle = 0;
    bit    known = 0;

    always @(negedge clk) begin
        int          n;
        bit          expRspValid;
        bit          canAccept;
        bit          found;
        int          g;
        int          idx;
        logic [N-1:0] expReady;
        item_t       it;

        if (rst) begin
            if (known) begin
                checkOutput("ready_in_reset", 64'(reqReady), 64'(0));
            end
            inFlight.delete();
            mPtr  = 0;
            known = 1;
        end else if (known) begin
            n           = inFlight.size();
            expRspValid = (n > 0) && (cycle - inFlight[0].cyc >= 2);
            checkOutput("rsp_valid", 64'(rspValid), 64'(expRspValid));
            if (expRspValid && rspValid) begin
                checkOutput("rsp_id", 64'(rspId), 64'(inFlight[0].id));
                checkOutput("rsp_prod", 64'(rspProd), 64'(inFlight[0].prod));
            end

            canAccept = (n < 2) || (expRspValid && rspReady);
            found = 0;
            g     = 0;
            for (int k = 0; k < N; k++) begin
                idx = (mPtr + k) % N;
                if (!found && reqValid[idx]) begin
                    found = 1;
                    g     = idx;
                end
            end
            expReady = (canAccept && found) ? N'(1 << g) : '0;
            checkOutput("req_ready", 64'(reqReady), 64'(expReady));

            if (expRspValid && rspReady) begin
                void'(inFlight.pop_front());
            end
            if (canAccept && found) begin
                it.id   = g;
                it.prod = prodModel(reqA[g*32 +: 32], reqB[g*32 +: 32]);
                it.cyc  = cycle;
                inFlight.push_back(it);
                mPtr = (g + 1) % N;
            end
        end
        cycle++;
    end

    // ---------------------------------------------------------------------
    // Directed scenarios followed by randomized traffic.
    // ---------------------------------------------------------------------
    initial begin
        logic [N-1:0] lastAcc;
        int           accCount;
        int           id1Count;
        int           order [8];

        for (int j = 0; j < 8; j++) order[j] = j % N;

        // Reset with every requester asking: nothing may be accepted.
        applyStimulus('1, 1'b1);
        @(negedge clk);
        checkOutput("reset_ready", 64'(reqReady), 64'(0));
        toNextCycle();
        @(negedge clk);
        checkOutput("reset_ready2", 64'(reqReady), 64'(0));
        toNextCycle();
        applyStimulus('0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_rsp_valid", 64'(rspValid), 64'(0));
        checkOutput("reset_rsp_id", 64'(rspId), 64'(0));
        checkOutput("reset_rsp_prod", 64'(rspProd), 64'(0));
        toNextCycle();

        // Single request from requester 2: 2.0 * 1.5.
        setOps(2, 32'h0200_0000, 32'h0180_0000);
        applyStimulus(4'b0100, 1'b1);
        @(negedge clk);
        checkOutput("single_ready", 64'(reqReady), 64'h4);
        toNextCycle();
        applyStimulus('0, 1'b1);
        @(negedge clk);
        checkOutput("single_lat1", 64'(rspValid), 64'(0));
        toNextCycle();
        @(negedge clk);
        checkOutput("single_lat2", 64'(rspValid), 64'(1));
        checkOutput("single_id", 64'(rspId), 64'(2));
        checkOutput("single_prod", 64'(rspProd), 64'h0300_0000);
        toNextCycle();

        // Signed operands through requester 0: -1.0 * 0.25, then a tiny product.
        setOps(0, 32'hFF00_0000, 32'h0040_0000);
        applyStimulus(4'b0001, 1'b1);
        toNextCycle();
        setOps(0, 32'h0000_1000, 32'h0030_0000);
        toNextCycle();
        applyStimulus('0, 1'b1);
        @(negedge clk);
        checkOutput("signed_prod", 64'(rspProd), 64'hFFC0_0000);
        toNextCycle();
        @(negedge clk);
        checkOutput("small_prod", 64'(rspProd), 64'h0000_0300);
        toNextCycle();
        toNextCycle();

        // Fairness: all four hold valid, fresh operands after each acceptance.
        doReset();
        for (int i = 0; i < N; i++) setOps(i, 32'h0100_0000 * (i + 1), 32'h0080_0000 + 32'(i));
        applyStimulus('1, 1'b1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            checkOutput("fair_grant", 64'(reqReady), 64'(1 << order[j]));
            lastAcc = reqValid & reqReady;
            toNextCycle();
            for (int i = 0; i < N; i++)
                if (lastAcc[i]) setOps(i, $urandom, $urandom);
        end
        applyStimulus('0, 1'b1);
        repeat (4) toNextCycle();

        // Backpressure: consumer stalls for 5 cycles with requesters 1 and 3 asking.
        accCount = 0;
        setOps(1, 32'h0300_0000, 32'h0200_0000);
        setOps(3, 32'hFE00_0000, 32'h0100_0000);
        applyStimulus(4'b1010, 1'b0);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            accCount += $countones(reqReady);
            if (j >= 2) checkOutput("bp_ready_low", 64'(reqReady), 64'(0));
            lastAcc = reqValid & reqReady;
            toNextCycle();
            for (int i = 0; i < N; i++)
                if (lastAcc[i]) setOps(i, $urandom, $urandom);
        end
        checkOutput("bp_accepts", 64'(accCount), 64'(2));
        applyStimulus('0, 1'b1);
        @(negedge clk);
        checkOutput("bp_first_id", 64'(rspId), 64'(1));
        checkOutput("bp_first_prod", 64'(rspProd), 64'h0600_0000);
        toNextCycle();
        @(negedge clk);
        checkOutput("bp_second_valid", 64'(rspValid), 64'(1));
        checkOutput("bp_second_id", 64'(rspId), 64'(3));
        checkOutput("bp_second_prod", 64'(rspProd), 64'hFE00_0000);
        toNextCycle();
        repeat (3) toNextCycle();

        // Reset mid-operation with both stages full.
        for (int i = 0; i < N; i++) setOps(i, $urandom, $urandom);
        applyStimulus('1, 1'b0);
        repeat (3) toNextCycle();
        rst = 1'b1;
        toNextCycle();
        rst = 1'b0;
        rspReady = 1'b1;
        @(negedge clk);
        checkOutput("midrst_rsp_valid", 64'(rspValid), 64'(0));
        checkOutput("midrst_first_grant", 64'(reqReady), 64'h1);
        toNextCycle();
        applyStimulus('0, 1'b1);
        repeat (4) toNextCycle();

        // Withdrawn request: requester 1 asks for one cycle while 0 wins.
        doReset();
        setOps(0, 32'h0100_0000, 32'h0100_0000);
        setOps(1, 32'h0500_0000, 32'h0100_0000);
        applyStimulus(4'b0011, 1'b1);
        @(negedge clk);
        checkOutput("withdraw_grant", 64'(reqReady), 64'h1);
        toNextCycle();
        applyStimulus('0, 1'b1);
        id1Count = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (rspValid && rspId == 2'd1) id1Count++;
            toNextCycle();
        end
        checkOutput("withdraw_no_id1", 64'(id1Count), 64'(0));

        // Randomized traffic obeying the hold-until-ready rule, with
        // occasional withdrawals, consumer stalls and reset pulses.
        lastAcc = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            lastAcc = reqValid & reqReady;
            toNextCycle();
            rst = ($urandom_range(0, 299) == 0);
            rspReady = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (lastAcc[i] || !reqValid[i]) begin
                    reqValid[i] = ($urandom_range(0, 1) == 1);
                    if ($urandom_range(0, 3) == 0)
                        setOps(i, 32'($signed($urandom_range(0, 65535)) - 32768) <<< 12, $urandom);
                    else
                        setOps(i, $urandom, $urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    reqValid[i] = 1'b0;
                end
            end
        end
        rst = 1'b0;
        applyStimulus('0, 1'b1);
        repeat (6) toNextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
